// File: rtl/qc_cyclic_shifter_pipe_if.sv
// Handshake bundle for the QC-LDPC pipelined cyclic shifter.
// The slave modport is the shifter's view; the master modport is the view
// of the block that feeds vectors in and drains rotated vectors out.
interface qc_cyclic_shifter_pipe_if #(
  parameter int BITS = 8,
  parameter int ZMAX = 16,
  parameter int LOGZ = $clog2(ZMAX)
);
  logic                 in_valid;
  logic                 in_ready;
  logic [ZMAX*BITS-1:0] in_data;
  logic [LOGZ:0]        z_size;
  logic [LOGZ-1:0]      shift;
  logic                 dir;
  logic                 out_valid;
  logic                 out_ready;
  logic [ZMAX*BITS-1:0] out_data;
  logic                 out_err;

  modport master (
    output in_valid, in_data, z_size, shift, dir, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, z_size, shift, dir, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/qc_cyclic_shifter_pipe.sv
// Two-stage runtime-configurable cyclic shifter for the QC-LDPC message path.
// S1 captures the vector and reduces (z_size, shift, dir) to a single forward
// rotation plus an illegal-config flag; S2 applies the rotation and is the
// output register. Two vectors of buffering give full throughput under
// backpressure; in_ready is the only combinational path (from out_ready).
module qc_cyclic_shifter_pipe #(
  parameter int BITS = 8,
  parameter int ZMAX = 16,
  parameter int LOGZ = $clog2(ZMAX)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  qc_cyclic_shifter_pipe_if.slave   bus
);

  localparam int            W      = ZMAX * BITS;
  localparam int            IW     = LOGZ + 2;
  localparam logic [LOGZ:0] ZMAX_V = (LOGZ + 1)'(ZMAX);

  // An inverse rotation by s over z lanes is a forward rotation by z - s.
  function automatic logic [LOGZ-1:0] eff_rot(
    input logic [LOGZ:0]   z,
    input logic [LOGZ-1:0] sh,
    input logic            inv
  );
    logic [LOGZ:0] diff;
    diff = z - {1'b0, sh};
    if (inv && (sh != {LOGZ{1'b0}})) begin
      eff_rot = diff[LOGZ-1:0];
    end else begin
      eff_rot = sh;
    end
  endfunction

  // Lifting size outside 1..ZMAX or a shift not below it is unusable.
  function automatic logic cfg_err(
    input logic [LOGZ:0]   z,
    input logic [LOGZ-1:0] sh
  );
    cfg_err = (z == {(LOGZ + 1){1'b0}}) || (z > ZMAX_V) || ({1'b0, sh} >= z);
  endfunction

  // Forward rotation of the first z lanes; lanes at or above z read as zero.
  // Requires rot < z <= ZMAX, which S1 guarantees for legal vectors.
  function automatic logic [W-1:0] rotate_lanes(
    input logic [W-1:0]    data,
    input logic [LOGZ:0]   z,
    input logic [LOGZ-1:0] rot
  );
    logic [W-1:0]  res;
    logic [IW-1:0] idx;
    logic [IW-1:0] zx;
    res = {W{1'b0}};
    zx  = {1'b0, z};
    for (int i = 0; i < ZMAX; i++) begin
      idx = IW'(i) + IW'(rot);
      if (idx >= zx) begin
        idx = idx - zx;
      end else begin
        idx = idx;
      end
      if (IW'(i) < zx) begin
        res[i*BITS +: BITS] = data[idx*BITS +: BITS];
      end else begin
        res[i*BITS +: BITS] = {BITS{1'b0}};
      end
    end
    rotate_lanes = res;
  endfunction

  logic            s1_valid_q, s1_valid_d;
  logic [W-1:0]    s1_data_q,  s1_data_d;
  logic [LOGZ:0]   s1_z_q,     s1_z_d;
  logic [LOGZ-1:0] s1_rot_q,   s1_rot_d;
  logic            s1_err_q,   s1_err_d;
  logic            s2_valid_q, s2_valid_d;
  logic [W-1:0]    s2_data_q,  s2_data_d;
  logic            s2_err_q,   s2_err_d;

  logic            in_ready;
  logic            accept;
  logic            s2_load;

  // S1 may refill whenever it is empty or its content moves on this cycle.
  assign in_ready      = !s1_valid_q || !s2_valid_q || bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_err   = s2_err_q;

  // Handshake decode and next-state for both pipeline stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_z_d     = s1_z_q;
    s1_rot_d   = s1_rot_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_err_d   = s2_err_q;

    s2_load = s1_valid_q && (!s2_valid_q || bus.out_ready);
    accept  = bus.in_valid && in_ready;

    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_err_d   = s1_err_q;
      if (s1_err_q) begin
        s2_data_d = {W{1'b0}};
      end else begin
        s2_data_d = rotate_lanes(s1_data_q, s1_z_q, s1_rot_q);
      end
    end else if (s2_valid_q && bus.out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = bus.in_data;
      s1_z_d     = bus.z_size;
      s1_err_d   = cfg_err(bus.z_size, bus.shift);
      if (cfg_err(bus.z_size, bus.shift)) begin
        s1_rot_d = {LOGZ{1'b0}};
      end else begin
        s1_rot_d = eff_rot(bus.z_size, bus.shift, bus.dir);
      end
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Pipeline registers; reset discards any in-flight vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= {W{1'b0}};
      s1_z_q     <= {(LOGZ + 1){1'b0}};
      s1_rot_q   <= {LOGZ{1'b0}};
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= {W{1'b0}};
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_z_q     <= s1_z_d;
      s1_rot_q   <= s1_rot_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_err_q   <= s2_err_d;
    end
  end

endmodule

// File: tb/tb_qc_cyclic_shifter_pipe.sv
// Self-checking bench for qc_cyclic_shifter_pipe: directed vectors with
// hand-computed results, illegal configs, a randomized backpressure stream
// against a lane-index reference model, and reset while the pipe is full.
module tb_qc_cyclic_shifter_pipe;
  localparam int BITS = 8;
  localparam int ZMAX = 16;
  localparam int LOGZ = 4;
  localparam int W    = ZMAX * BITS;

  typedef struct {
    logic [W-1:0] d;
    logic         e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  qc_cyclic_shifter_pipe_if #(.BITS(BITS), .ZMAX(ZMAX), .LOGZ(LOGZ)) bus();

  qc_cyclic_shifter_pipe #(.BITS(BITS), .ZMAX(ZMAX), .LOGZ(LOGZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: out[i] = in[(i +/- shift) mod z] for i < z, zero elsewhere.
  function automatic bit model_err(input int z, input int sh);
    return (z < 1) || (z > ZMAX) || (sh >= z);
  endfunction

  function automatic logic [W-1:0] model_data(input logic [W-1:0] d, input int z,
                                              input int sh, input bit inv);
    logic [W-1:0] r;
    int src;
    r = '0;
    if (model_err(z, sh)) return r;
    for (int i = 0; i < z; i++) begin
      if (inv) src = (((i - sh) % z) + z) % z;
      else     src = (i + sh) % z;
      r[i*BITS +: BITS] = d[src*BITS +: BITS];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one vector into an empty pipe with out_ready high; report the result
  // and how many cycles after acceptance out_valid appeared (-1 on timeout).
  task automatic send_one(input logic [W-1:0] d, input int z, input int sh, input bit inv,
                          output logic [W-1:0] got, output logic gerr, output int lat);
    int n;
    got = '0; gerr = 1'b0; lat = -1;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.z_size    = (LOGZ + 1)'(z);
    bus.shift     = LOGZ'(sh);
    bus.dir       = inv;
    bus.out_ready = 1'b1;
    #1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      if (bus.out_valid) begin
        got = bus.out_data; gerr = bus.out_err; lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_err !== 1'b0 || bus.out_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b err=%b data=%h, want 0/0/0",
               bus.out_valid, bus.out_err, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got in_ready=%b out_valid=%b, want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_rotate_directed();
    logic [W-1:0] d, got, exp, got2;
    logic gerr;
    int lat;
    int e_fwd [7] = '{5, 6, 7, 1, 2, 3, 4};
    int e_inv [7] = '{4, 5, 6, 7, 1, 2, 3};
    for (int i = 0; i < ZMAX; i++) d[i*BITS +: BITS] = (i < 7) ? 8'(i + 1) : 8'd9;

    send_one(d, 7, 4, 1'b0, got, gerr, lat);
    exp = '0;
    for (int i = 0; i < 7; i++) exp[i*BITS +: BITS] = 8'(e_fwd[i]);
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL fwd_z7_s4: got %h want %h", got, exp);
    end
    checks++;
    if (gerr !== 1'b0) begin
      failures++; $display("FAIL fwd_z7_s4_err: got %b want 0", gerr);
    end
    checks++;
    if (lat != 2) begin
      failures++; $display("FAIL latency: got %0d want 2", lat);
    end

    send_one(d, 7, 4, 1'b1, got2, gerr, lat);
    exp = '0;
    for (int i = 0; i < 7; i++) exp[i*BITS +: BITS] = 8'(e_inv[i]);
    checks++;
    if (got2 !== exp) begin
      failures++; $display("FAIL inv_z7_s4: got %h want %h", got2, exp);
    end

    send_one(got2, 7, 4, 1'b0, got, gerr, lat);
    exp = '0;
    for (int i = 0; i < 7; i++) exp[i*BITS +: BITS] = 8'(i + 1);
    checks++;
    if (got !== exp || gerr !== 1'b0) begin
      failures++; $display("FAIL roundtrip: got %h err=%b want %h err=0", got, gerr, exp);
    end
  endtask

  task automatic test_signed_full();
    logic [W-1:0] d, got;
    logic gerr;
    int lat;
    for (int i = 0; i < ZMAX; i++) d[i*BITS +: BITS] = 8'(i - 8);
    send_one(d, 16, 15, 1'b0, got, gerr, lat);
    checks++;
    if (got[0 +: BITS] !== 8'h07 || got[BITS +: BITS] !== 8'hF8) begin
      failures++;
      $display("FAIL signed_lanes01: got %h %h want 07 f8", got[0 +: BITS], got[BITS +: BITS]);
    end
    checks++;
    if (got !== model_data(d, 16, 15, 1'b0) || gerr !== 1'b0) begin
      failures++;
      $display("FAIL signed_z16_s15: got %h want %h", got, model_data(d, 16, 15, 1'b0));
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0] d, got;
    logic gerr;
    int lat;
    int zs [3] = '{5, 0, 17};
    int ss [3] = '{5, 0, 0};
    for (int k = 0; k < 3; k++) begin
      d = rand_vec();
      send_one(d, zs[k], ss[k], 1'b0, got, gerr, lat);
      checks++;
      if (got !== '0 || gerr !== 1'b1 || lat != 2) begin
        failures++;
        $display("FAIL illegal_z%0d_s%0d: got data=%h err=%b lat=%0d want 0/1/2",
                 zs[k], ss[k], got, gerr, lat);
      end
    end
    d = rand_vec();
    send_one(d, 9, 3, 1'b1, got, gerr, lat);
    checks++;
    if (got !== model_data(d, 9, 3, 1'b1) || gerr !== 1'b0) begin
      failures++;
      $display("FAIL after_illegal: got %h err=%b want %h err=0", got, gerr, model_data(d, 9, 3, 1'b1));
    end
  endtask

  task automatic test_backpressure();
    exp_t q [$];
    exp_t ex;
    int sent = 0, recv = 0, occ = 0, cyc = 0;
    int nz, nsh;
    bit ninv, stall_prev = 1'b0, acc, cons, exp_rdy;
    logic [W-1:0] nd, prev_d;
    logic prev_e;
    prev_d = '0; prev_e = 1'b0;
    while (recv < 20 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      nd = rand_vec();
      nz = (($urandom % 8) == 0) ? int'($urandom_range(31, 0)) : int'($urandom_range(16, 1));
      if (nz >= 1 && nz <= ZMAX && ($urandom % 8) != 0) nsh = $urandom_range(nz - 1, 0);
      else nsh = $urandom_range(15, 0);
      ninv = $urandom % 2;
      bus.in_valid  = (sent < 20) && (($urandom % 2) == 0);
      bus.in_data   = nd;
      bus.z_size    = (LOGZ + 1)'(nz);
      bus.shift     = LOGZ'(nsh);
      bus.dir       = ninv;
      bus.out_ready = ($urandom % 2) == 0;
      #1;
      exp_rdy = !(occ == 2 && !bus.out_ready);
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        failures++;
        $display("FAIL bp_in_ready: cyc %0d got %b want %b (held=%0d)", cyc, bus.in_ready, exp_rdy, occ);
      end
      if (stall_prev) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_d || bus.out_err !== prev_e) begin
          failures++;
          $display("FAIL bp_hold: cyc %0d got v=%b d=%h e=%b want 1 %h %b",
                   cyc, bus.out_valid, bus.out_data, bus.out_err, prev_d, prev_e);
        end
      end
      if (bus.out_valid) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL bp_spurious: cyc %0d got out_valid=1 want 0 (nothing in flight)", cyc);
        end else if (bus.out_data !== q[0].d || bus.out_err !== q[0].e) begin
          failures++;
          $display("FAIL bp_data: vec %0d got %h err=%b want %h err=%b",
                   recv, bus.out_data, bus.out_err, q[0].d, q[0].e);
        end
      end
      acc  = bus.in_valid && bus.in_ready;
      cons = bus.out_valid && bus.out_ready;
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_d = bus.out_data;
      prev_e = bus.out_err;
      if (cons) begin
        if (q.size() > 0) void'(q.pop_front());
        recv++;
        occ--;
      end
      if (acc) begin
        ex.d = model_data(nd, nz, nsh, ninv);
        ex.e = model_err(nz, nsh);
        q.push_back(ex);
        sent++;
        occ++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (recv != 20 || q.size() != 0) begin
      failures++;
      $display("FAIL bp_count: got %0d outputs (%0d left) want 20 (0 left)", recv, q.size());
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = rand_vec();
    bus.z_size    = 5'd8;
    bus.shift     = 4'd1;
    bus.dir       = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_data   = rand_vec();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_stall: got out_valid=%b in_ready=%b want 1/0", bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_err !== 1'b0 || bus.out_data !== '0) begin
      failures++;
      $display("FAIL async_reset: got v=%b e=%b d=%h want 0/0/0", bus.out_valid, bus.out_err, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL no_stale: cyc %0d got out_valid=%b in_ready=%b want 0/1", c, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.z_size    = '0;
    bus.shift     = '0;
    bus.dir       = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_rotate_directed();
    test_signed_full();
    test_illegal();
    test_backpressure();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qc_cyclic_shifter_pipe.md
Name: qc_cyclic_shifter_pipe

Overview:
- Pipelined, runtime-configurable cyclic shifter for the QC-LDPC decoder message datapath.
- Rotates the first z_size lanes of a ZMAX-lane vector of signed BITS-bit messages by a runtime shift amount, in either direction.
- Successor to the fixed-Z combinational barrel shifter: adds runtime lifting size, forward/inverse direction, valid/ready handshake with backpressure, two-stage pipeline and illegal-configuration flagging.
- Sits between the message memories and the VN/CN processing units.

Parameters:
- BITS, 8, width of one signed message lane.
- ZMAX, 16, maximum lifting size (lane count); must be ≥ 2.
- LOGZ, $clog2(ZMAX), width of the shift port.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept input this cycle.
- in_data  in  ZMAX*BITS  lane i at [i*BITS +: BITS].
- z_size  in  LOGZ+1  active lane count, legal range 1..ZMAX; sampled with in_data.
- shift  in  LOGZ  rotation amount, legal range 0..z_size-1.
- dir  in  1  0 = forward, 1 = inverse.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  ZMAX*BITS  rotated vector, same lane packing as in_data.
- out_err  out  1  illegal config for the current output; qualified by out_valid.

Behaviour:
- Reset (async assert, sync deassert by clk) clears everything:
  - out_valid=0, out_data=0, out_err=0.
  - Both stage valid bits = 0.
  - in_ready=1 from the first cycle after reset.
- Transfer rules:
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
  - in_data, z_size, shift and dir are sampled only on acceptance.
- Rotation semantics, for lanes i < z_size:
  - dir=0: out[i] = in[(i+shift) mod z_size].
  - dir=1: out[i] = in[(i-shift) mod z_size].
  - Lanes i ≥ z_size output 0.
  - Lane values pass through unmodified: no saturation, no sign change.
- Illegal config (z_size==0, z_size>ZMAX, or shift≥z_size):
  - Whole out_data = 0 and out_err=1 for that vector.
  - The vector still occupies its pipeline slot and is emitted in order; no other side effect.
- Pipeline:
  - Two register stages, S1 (captures input, resolves effective rotation and the error flag) and S2 (the output register).
  - Latency exactly 2 cycles from acceptance to out_valid when unstalled.
  - Throughput 1 vector/cycle.
- Stall and ready rules:
  - S2 loads when S1 valid && (!S2 valid || out_ready).
  - S1 loads when it is empty or moving to S2 in the same cycle.
  - in_ready = !S1_valid || !S2_valid || out_ready (combinational from out_ready; no other combinational input-to-output paths).
- Output hold: out_data, out_err and out_valid hold stable while out_valid && !out_ready.
- Capacity: 2 vectors. With both stages full and out_ready=0, in_ready=0.
- Simultaneous accept and consume when full: both happen in the same cycle, so there are no bubbles.
- Ordering: strict FIFO; none dropped, none duplicated.
- Reset mid-operation: all in-flight vectors discarded; out_valid drops immediately (async).
- shift=0 or z_size=1: identity on the active lanes (for z_size=1, shift must be 0).

Test Plan:
- ZMAX=16, z_size=7, shift=4, dir=0, lanes 0..6 = 1..7 (others 9) -> out lanes 0..6 = 5,6,7,1,2,3,4; lanes 7..15 = 0; out_err=0; out_valid exactly 2 cycles after acceptance.
- Same vector, dir=1 -> lanes 0..6 = 4,5,6,7,1,2,3. Then feed that output back with dir=0, shift=4 -> original 1..7 restored.
- z_size=16, shift=15, dir=0, lane i = i-8 (signed, -8..7) -> out[0]=7, out[1]=-8, …, out[15]=6; negative values preserved bit-exact.
- Illegal configs: z_size=5 with shift=5; z_size=0; z_size=17 -> out_err=1, out_data all zero. The next legal vector following it is correct, with out_err=0.
- Backpressure: stream 20 random vectors with random in_valid and out_ready (~50% each) -> outputs in order and match the model; output held stable while stalled; in_ready=0 only when 2 vectors are held and out_ready=0.
- Assert rst_n low while 2 vectors are in flight -> out_valid=0 immediately; after release in_ready=1 and no stale vector emerges.
